// File: rtl/seq_controller.sv
// ---------------------------------------------------------------------------
// seq_controller
// Multi-cycle control unit for the simple processor. It fetches an instruction
// from ROM, decodes it, and then spends several cycles driving register-file,
// ALU, immediate and RAM strobes for that instruction.
//
// Optional feature macro: SEQ_CTRL_STEP_EN
//   When defined, an i_step input is added. After each instruction the
//   controller waits in PAUSE until i_step is seen high.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             run enable, checked in IDLE before every fetch
//   i_rom_ready         ROM data on i_ir is valid
//   i_ir                instruction {opcode, rd, addr/imm}; rs = top RF_AW bits of addr
//   i_alu_zero          ALU zero flag, used by JZ/JNZ
//   i_step              (SEQ_CTRL_STEP_EN only) leave PAUSE
//   o_pc, o_rom_en      ROM address and fetch request
//   o_en_rf, o_r_wf     RF enable; r_wf 1 = read, 0 = write
//   o_sel_rf            RF address
//   o_en_reg/alu/imm    operand register, ALU and immediate register strobes
//   o_sel_alu           000 pass, 001 zero-test, 010 add, 011 sub, 100 shl
//   o_sel_mux           ALU B source: 00 imm, 01 RF, 10 RAM
//   o_imm               immediate value
//   o_cs_ram, o_wr_ram  RAM select / write, o_addr_ram RAM address
//   o_halted            HALT executed
//   o_illegal           one-cycle pulse on an undefined opcode
//
// State   | meaning
// IDLE    | waiting for i_start
// FETCH   | rom_en high until i_rom_ready, instruction latched
// DECODE  | pc incremented, dispatch on opcode
// E1..E5  | execute cycles, count depends on opcode
// RETIRE  | instruction finished
// HALTED  | HALT executed, held until reset
// PAUSE   | (SEQ_CTRL_STEP_EN) waiting for i_step
// ---------------------------------------------------------------------------
module seq_controller #(
    parameter  int PC_W  = 8,
    parameter  int RF_AW = 4,
    localparam int IR_W  = 4 + RF_AW + PC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_rom_ready,
`ifdef SEQ_CTRL_STEP_EN
    input  logic              i_step,
`endif
    input  logic [IR_W-1:0]   i_ir,
    input  logic              i_alu_zero,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_rom_en,
    output logic              o_en_rf,
    output logic              o_r_wf,
    output logic [RF_AW-1:0]  o_sel_rf,
    output logic              o_en_reg,
    output logic              o_en_alu,
    output logic              o_en_imm,
    output logic [2:0]        o_sel_alu,
    output logic [1:0]        o_sel_mux,
    output logic [PC_W-1:0]   o_imm,
    output logic              o_cs_ram,
    output logic              o_wr_ram,
    output logic [PC_W-1:0]   o_addr_ram,
    output logic              o_halted,
    output logic              o_illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_E1, S_E2, S_E3, S_E4, S_E5,
        S_RETIRE, S_HALTED
`ifdef SEQ_CTRL_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    localparam logic [3:0] OP_MOV   = 4'b0010;
    localparam logic [3:0] OP_LOADI = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_JZ    = 4'b0110;
    localparam logic [3:0] OP_SHL   = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1001;
    localparam logic [3:0] OP_JNZ   = 4'b1010;
    localparam logic [3:0] OP_JMP   = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_op;
    logic [RF_AW-1:0]   r_rd, r_rs;
    logic [PC_W-1:0]    r_addr;

    logic [PC_W-1:0]    r_pc, w_pc_nxt;
    logic               r_rom_en, w_rom_en_nxt;
    logic               r_en_rf, w_en_rf_nxt;
    logic               r_r_wf, w_r_wf_nxt;
    logic [RF_AW-1:0]   r_sel_rf, w_sel_rf_nxt;
    logic               r_en_reg, w_en_reg_nxt;
    logic               r_en_alu, w_en_alu_nxt;
    logic               r_en_imm, w_en_imm_nxt;
    logic [2:0]         r_sel_alu, w_sel_alu_nxt;
    logic [1:0]         r_sel_mux, w_sel_mux_nxt;
    logic [PC_W-1:0]    r_imm, w_imm_nxt;
    logic               r_cs_ram, w_cs_ram_nxt;
    logic               r_wr_ram, w_wr_ram_nxt;
    logic [PC_W-1:0]    r_addr_ram, w_addr_ram_nxt;
    logic               r_halted, w_halted_nxt;
    logic               r_illegal, w_illegal_nxt;

    logic [2:0]         w_len;
    logic [2:0]         w_step;
    logic [2:0]         w_nstep;

    // Number of execute cycles; zero marks an undefined opcode.
    function automatic logic [2:0] exec_len(input logic [3:0] op);
        case (op)
            OP_LOADI, OP_MOV, OP_JZ, OP_JNZ, OP_STORE, OP_LOAD: exec_len = 3'd3;
            OP_ADD, OP_SUB, OP_SHL:                             exec_len = 3'd5;
            OP_JMP:                                             exec_len = 3'd1;
            default:                                            exec_len = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] e_index(input state_t s);
        case (s)
            S_E1:    e_index = 3'd1;
            S_E2:    e_index = 3'd2;
            S_E3:    e_index = 3'd3;
            S_E4:    e_index = 3'd4;
            S_E5:    e_index = 3'd5;
            default: e_index = 3'd0;
        endcase
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_rd       <= '0;
            r_rs       <= '0;
            r_addr     <= '0;
            r_pc       <= '0;
            r_rom_en   <= 1'b0;
            r_en_rf    <= 1'b0;
            r_r_wf     <= 1'b0;
            r_sel_rf   <= '0;
            r_en_reg   <= 1'b0;
            r_en_alu   <= 1'b0;
            r_en_imm   <= 1'b0;
            r_sel_alu  <= 3'b000;
            r_sel_mux  <= 2'b01;
            r_imm      <= '0;
            r_cs_ram   <= 1'b0;
            r_wr_ram   <= 1'b0;
            r_addr_ram <= '0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            if (r_state == S_FETCH && i_rom_ready) begin
                r_op   <= i_ir[IR_W-1 -: 4];
                r_rd   <= i_ir[PC_W+RF_AW-1 -: RF_AW];
                r_rs   <= i_ir[PC_W-1 -: RF_AW];
                r_addr <= i_ir[PC_W-1:0];
            end
            r_pc       <= w_pc_nxt;
            r_rom_en   <= w_rom_en_nxt;
            r_en_rf    <= w_en_rf_nxt;
            r_r_wf     <= w_r_wf_nxt;
            r_sel_rf   <= w_sel_rf_nxt;
            r_en_reg   <= w_en_reg_nxt;
            r_en_alu   <= w_en_alu_nxt;
            r_en_imm   <= w_en_imm_nxt;
            r_sel_alu  <= w_sel_alu_nxt;
            r_sel_mux  <= w_sel_mux_nxt;
            r_imm      <= w_imm_nxt;
            r_cs_ram   <= w_cs_ram_nxt;
            r_wr_ram   <= w_wr_ram_nxt;
            r_addr_ram <= w_addr_ram_nxt;
            r_halted   <= w_halted_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    // Outputs are registered, so they are computed from the state being
    // entered: the strobes of E<n> are visible while the FSM sits in E<n>.
    always_comb begin
        w_len          = exec_len(r_op);
        w_step         = e_index(r_state);
        w_state_nxt    = r_state;

        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_FETCH;
            S_FETCH:  if (i_rom_ready) w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (r_op == OP_HALT)     w_state_nxt = S_HALTED;
                else if (w_len == 3'd0)  w_state_nxt = S_RETIRE;
                else                     w_state_nxt = S_E1;
            end
            S_E1, S_E2, S_E3, S_E4, S_E5: begin
                if (w_step >= w_len) w_state_nxt = S_RETIRE;
                else begin
                    case (w_step)
                        3'd1:    w_state_nxt = S_E2;
                        3'd2:    w_state_nxt = S_E3;
                        3'd3:    w_state_nxt = S_E4;
                        default: w_state_nxt = S_E5;
                    endcase
                end
            end
`ifdef SEQ_CTRL_STEP_EN
            S_RETIRE: w_state_nxt = S_PAUSE;
            S_PAUSE:  if (i_step) w_state_nxt = S_IDLE;
`else
            S_RETIRE: w_state_nxt = S_IDLE;
`endif
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_IDLE;
        endcase

        w_nstep        = e_index(w_state_nxt);

        w_pc_nxt       = r_pc;
        w_rom_en_nxt   = (w_state_nxt == S_FETCH);
        w_en_rf_nxt    = 1'b0;
        w_r_wf_nxt     = r_r_wf;
        w_sel_rf_nxt   = r_sel_rf;
        w_en_reg_nxt   = 1'b0;
        w_en_alu_nxt   = 1'b0;
        w_en_imm_nxt   = 1'b0;
        w_sel_alu_nxt  = r_sel_alu;
        w_sel_mux_nxt  = 2'b01;
        w_imm_nxt      = r_imm;
        w_cs_ram_nxt   = 1'b0;
        w_wr_ram_nxt   = 1'b0;
        w_addr_ram_nxt = r_addr_ram;
        w_halted_nxt   = (w_state_nxt == S_HALTED);
        w_illegal_nxt  = (r_state == S_DECODE) && (w_state_nxt == S_RETIRE);

        // Jump targets are applied after DECODE, so they override its increment.
        if (r_state == S_DECODE)
            w_pc_nxt = r_pc + PC_W'(1);
        if (r_state == S_E1 && r_op == OP_JMP)
            w_pc_nxt = r_addr;
        if (r_state == S_E3 && ((r_op == OP_JZ && i_alu_zero) ||
                                (r_op == OP_JNZ && !i_alu_zero)))
            w_pc_nxt = r_addr;

        case (r_op)
            OP_LOADI: case (w_nstep)
                3'd1: begin w_imm_nxt = r_addr; w_en_imm_nxt = 1'b1; end
                3'd2: begin w_sel_mux_nxt = 2'b00; w_en_alu_nxt = 1'b1; w_sel_alu_nxt = 3'b000; end
                3'd3: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b0; w_sel_rf_nxt = r_rd; end
                default: ;
            endcase
            OP_MOV: case (w_nstep)
                3'd1: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b1; w_sel_rf_nxt = r_rs; end
                3'd2: begin w_en_alu_nxt = 1'b1; w_sel_alu_nxt = 3'b000; end
                3'd3: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b0; w_sel_rf_nxt = r_rd; end
                default: ;
            endcase
            OP_ADD, OP_SUB: case (w_nstep)
                3'd1: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b1; w_sel_rf_nxt = r_rs; end
                3'd2: w_en_reg_nxt = 1'b1;
                3'd3: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b1; w_sel_rf_nxt = r_rd; end
                3'd4: begin
                    w_en_alu_nxt  = 1'b1;
                    w_sel_alu_nxt = (r_op == OP_ADD) ? 3'b010 : 3'b011;
                end
                3'd5: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b0; w_sel_rf_nxt = r_rd; end
                default: ;
            endcase
            OP_SHL: case (w_nstep)
                3'd1: begin w_imm_nxt = r_addr; w_en_imm_nxt = 1'b1; end
                3'd2: begin w_sel_mux_nxt = 2'b00; w_en_reg_nxt = 1'b1; end
                3'd3: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b1; w_sel_rf_nxt = r_rd; end
                3'd4: begin w_en_alu_nxt = 1'b1; w_sel_alu_nxt = 3'b100; end
                3'd5: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b0; w_sel_rf_nxt = r_rd; end
                default: ;
            endcase
            OP_JZ, OP_JNZ: case (w_nstep)
                3'd1: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b1; w_sel_rf_nxt = r_rd; end
                3'd2: begin w_en_alu_nxt = 1'b1; w_sel_alu_nxt = 3'b001; end
                default: ;
            endcase
            OP_STORE: case (w_nstep)
                3'd1: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b1; w_sel_rf_nxt = r_rd; end
                3'd2: begin w_en_alu_nxt = 1'b1; w_sel_alu_nxt = 3'b000; end
                3'd3: begin w_cs_ram_nxt = 1'b1; w_wr_ram_nxt = 1'b1; w_addr_ram_nxt = r_addr; end
                default: ;
            endcase
            OP_LOAD: case (w_nstep)
                3'd1: begin w_cs_ram_nxt = 1'b1; w_wr_ram_nxt = 1'b0; w_addr_ram_nxt = r_addr; end
                3'd2: begin w_sel_mux_nxt = 2'b10; w_en_alu_nxt = 1'b1; w_sel_alu_nxt = 3'b000; end
                3'd3: begin w_en_rf_nxt = 1'b1; w_r_wf_nxt = 1'b0; w_sel_rf_nxt = r_rd; end
                default: ;
            endcase
            default: ;
        endcase
    end

    assign o_pc       = r_pc;
    assign o_rom_en   = r_rom_en;
    assign o_en_rf    = r_en_rf;
    assign o_r_wf     = r_r_wf;
    assign o_sel_rf   = r_sel_rf;
    assign o_en_reg   = r_en_reg;
    assign o_en_alu   = r_en_alu;
    assign o_en_imm   = r_en_imm;
    assign o_sel_alu  = r_sel_alu;
    assign o_sel_mux  = r_sel_mux;
    assign o_imm      = r_imm;
    assign o_cs_ram   = r_cs_ram;
    assign o_wr_ram   = r_wr_ram;
    assign o_addr_ram = r_addr_ram;
    assign o_halted   = r_halted;
    assign o_illegal  = r_illegal;

endmodule

// File: tb/tb_seq_controller.sv
module tb_seq_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rom_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic [15:0] ir = '0;
`ifdef SEQ_CTRL_STEP_EN
    logic        step = 1'b1;
`endif
    logic [7:0]  pc, imm, addr_ram;
    logic        rom_en, en_rf, r_wf, en_reg, en_alu, en_imm;
    logic        cs_ram, wr_ram, halted, illegal;
    logic [3:0]  sel_rf;
    logic [2:0]  sel_alu;
    logic [1:0]  sel_mux;

    always #5 clk = ~clk;

    seq_controller #(.PC_W(8), .RF_AW(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_rom_ready(rom_ready),
`ifdef SEQ_CTRL_STEP_EN
        .i_step(step),
`endif
        .i_ir(ir), .i_alu_zero(alu_zero),
        .o_pc(pc), .o_rom_en(rom_en), .o_en_rf(en_rf), .o_r_wf(r_wf),
        .o_sel_rf(sel_rf), .o_en_reg(en_reg), .o_en_alu(en_alu), .o_en_imm(en_imm),
        .o_sel_alu(sel_alu), .o_sel_mux(sel_mux), .o_imm(imm),
        .o_cs_ram(cs_ram), .o_wr_ram(wr_ram), .o_addr_ram(addr_ram),
        .o_halted(halted), .o_illegal(illegal)
    );

    typedef struct packed {
        logic       en_rf;
        logic       r_wf;
        logic [3:0] sel_rf;
        logic       en_reg;
        logic       en_alu;
        logic       en_imm;
        logic [2:0] sel_alu;
        logic [1:0] sel_mux;
        logic [7:0] imm;
        logic       cs_ram;
        logic       wr_ram;
        logic [7:0] addr_ram;
        logic       illegal;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_pc = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic ev_t ev0();
        ev_t e = '0;
        e.sel_mux = 2'b01;
        return e;
    endfunction

    // Fields that only matter while their strobe is active are cleared.
    function automatic ev_t norm(input ev_t e);
        ev_t n = e;
        if (!n.en_rf) begin n.r_wf = 1'b0; n.sel_rf = '0; end
        if (!n.en_alu) n.sel_alu = '0;
        if (!n.en_imm) n.imm = '0;
        if (!n.cs_ram) begin n.wr_ram = 1'b0; n.addr_ram = '0; end
        return n;
    endfunction

    function automatic ev_t ev_rd(input logic [3:0] r);
        ev_t e = ev0(); e.en_rf = 1'b1; e.r_wf = 1'b1; e.sel_rf = r; return e;
    endfunction
    function automatic ev_t ev_wr(input logic [3:0] r);
        ev_t e = ev0(); e.en_rf = 1'b1; e.r_wf = 1'b0; e.sel_rf = r; return e;
    endfunction
    function automatic ev_t ev_reg(input logic [1:0] mux);
        ev_t e = ev0(); e.en_reg = 1'b1; e.sel_mux = mux; return e;
    endfunction
    function automatic ev_t ev_alu(input logic [2:0] sel, input logic [1:0] mux);
        ev_t e = ev0(); e.en_alu = 1'b1; e.sel_alu = sel; e.sel_mux = mux; return e;
    endfunction
    function automatic ev_t ev_imm(input logic [7:0] v);
        ev_t e = ev0(); e.en_imm = 1'b1; e.imm = v; return e;
    endfunction
    function automatic ev_t ev_ram(input logic wr, input logic [7:0] a);
        ev_t e = ev0(); e.cs_ram = 1'b1; e.wr_ram = wr; e.addr_ram = a; return e;
    endfunction
    function automatic ev_t ev_ill();
        ev_t e = ev0(); e.illegal = 1'b1; return e;
    endfunction

    // Monitor: every cycle with a datapath strobe is one scoreboard entry.
    initial begin
        ev_t act, e;
        forever begin
            @(negedge clk);
            if (!rst && (en_rf || en_reg || en_alu || en_imm || cs_ram || illegal)) begin
                act = norm({en_rf, r_wf, sel_rf, en_reg, en_alu, en_imm, sel_alu,
                            sel_mux, imm, cs_ram, wr_ram, addr_ram, illegal});
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_strobe: got %h expected none at %0t", act, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_event", 64'(act), 64'(e));
                end
            end
        end
    end

    // Issue one instruction from IDLE, hold rom_ready low for 'waits' fetch
    // cycles, let it run to completion and compare the resulting pc.
    task automatic exec(input logic [15:0] instr, input int waits, input logic [7:0] next_pc);
        int t, k;
        ir = instr;
        rom_ready = (waits == 0);
        start = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rom_en && t < 20) begin @(negedge clk); t++; end
        start = 1'b0;
        if (!rom_en) begin
            n_checks++;
            $display("FAIL fetch_timeout: got no rom_en expected rom_en within 20 cycles");
            return;
        end
        k = 0;
        while (rom_en && k < 40) begin
            k++;
            rom_ready = (k > waits);
            @(negedge clk);
        end
        check("rom_en_cycles", 64'(k), 64'(waits + 1));
        repeat (10) @(negedge clk);
        exp_pc = next_pc;
        check("pc", 64'(pc), 64'(exp_pc));
    endtask

    initial begin
        int t, cnt;
        repeat (2) @(negedge clk);
        check("reset_pc", 64'(pc), 64'h0);
        check("reset_sel_mux", 64'(sel_mux), 64'h1);
        check("reset_outputs",
              64'({rom_en, en_rf, r_wf, sel_rf, en_reg, en_alu, en_imm, sel_alu,
                   imm, cs_ram, wr_ram, addr_ram, halted, illegal}), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // LOADI r2,0x5A
        exp_q.push_back(ev_imm(8'h5A));
        exp_q.push_back(ev_alu(3'b000, 2'b00));
        exp_q.push_back(ev_wr(4'd2));
        exec(16'h325A, 0, 8'h01);

        // ADD r3,r1 with three not-ready fetch cycles
        exp_q.push_back(ev_rd(4'd1));
        exp_q.push_back(ev_reg(2'b01));
        exp_q.push_back(ev_rd(4'd3));
        exp_q.push_back(ev_alu(3'b010, 2'b01));
        exp_q.push_back(ev_wr(4'd3));
        exec(16'h4310, 3, 8'h02);

        // JZ / JNZ, taken and not taken
        alu_zero = 1'b1;
        exp_q.push_back(ev_rd(4'd0)); exp_q.push_back(ev_alu(3'b001, 2'b01));
        exec(16'h6020, 0, 8'h20);
        alu_zero = 1'b0;
        exp_q.push_back(ev_rd(4'd0)); exp_q.push_back(ev_alu(3'b001, 2'b01));
        exec(16'h6040, 1, 8'h21);
        exp_q.push_back(ev_rd(4'd1)); exp_q.push_back(ev_alu(3'b001, 2'b01));
        exec(16'hA130, 0, 8'h30);
        alu_zero = 1'b1;
        exp_q.push_back(ev_rd(4'd1)); exp_q.push_back(ev_alu(3'b001, 2'b01));
        exec(16'hA150, 0, 8'h31);

        // JMP to its own address, then to 0xFF; MOV at 0xFF wraps pc to 0
        exec(16'hB031, 0, 8'h31);
        exec(16'hB0FF, 0, 8'hFF);
        exp_q.push_back(ev_rd(4'd7));
        exp_q.push_back(ev_alu(3'b000, 2'b01));
        exp_q.push_back(ev_wr(4'd6));
        exec(16'h2670, 0, 8'h00);

        // STORE r4,0x10 then LOAD r5,0x10
        exp_q.push_back(ev_rd(4'd4));
        exp_q.push_back(ev_alu(3'b000, 2'b01));
        exp_q.push_back(ev_ram(1'b1, 8'h10));
        exec(16'h8410, 0, 8'h01);
        exp_q.push_back(ev_ram(1'b0, 8'h10));
        exp_q.push_back(ev_alu(3'b000, 2'b10));
        exp_q.push_back(ev_wr(4'd5));
        exec(16'h9510, 0, 8'h02);

        // SUB r1,r2 and SHL r2,3
        exp_q.push_back(ev_rd(4'd2));
        exp_q.push_back(ev_reg(2'b01));
        exp_q.push_back(ev_rd(4'd1));
        exp_q.push_back(ev_alu(3'b011, 2'b01));
        exp_q.push_back(ev_wr(4'd1));
        exec(16'h5120, 0, 8'h03);
        exp_q.push_back(ev_imm(8'h03));
        exp_q.push_back(ev_reg(2'b00));
        exp_q.push_back(ev_rd(4'd2));
        exp_q.push_back(ev_alu(3'b100, 2'b01));
        exp_q.push_back(ev_wr(4'd2));
        exec(16'h7203, 0, 8'h04);

        // Undefined opcodes: only the illegal pulse, pc advances
        exp_q.push_back(ev_ill());
        exec(16'h0000, 0, 8'h05);
        exp_q.push_back(ev_ill());
        exec(16'hC000, 0, 8'h06);

        // Reset while STORE is driving its RAM write
        exp_q.push_back(ev_rd(4'd4));
        exp_q.push_back(ev_alu(3'b000, 2'b01));
        exp_q.push_back(ev_ram(1'b1, 8'h10));
        ir = 16'h8410; rom_ready = 1'b1; start = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rom_en && t < 20) begin @(negedge clk); t++; end
        start = 1'b0;
        t = 0;
        while (!cs_ram && t < 20) begin @(negedge clk); t++; end
        check("store_ram_seen", 64'(cs_ram), 64'h1);
        #2 rst = 1'b1;
        #1 check("async_reset", 64'({cs_ram, wr_ram, pc}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 8'h00;
        @(negedge clk);

`ifdef SEQ_CTRL_STEP_EN
        step = 1'b0;
        exp_q.push_back(ev_imm(8'h5A));
        exp_q.push_back(ev_alu(3'b000, 2'b00));
        exp_q.push_back(ev_wr(4'd2));
        exec(16'h325A, 0, 8'h01);
        ir = 16'hB000; rom_ready = 1'b1; start = 1'b1;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (rom_en) cnt++; end
        check("pause_no_fetch", 64'(cnt), 64'h0);
        step = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rom_en && t < 10) begin @(negedge clk); t++; end
        check("fetch_after_step", 64'(rom_en), 64'h1);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pc_after_step_jmp", 64'(pc), 64'h0);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'h0);

        // HALT holds with start still high
        ir = 16'hF000; rom_ready = 1'b1; start = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rom_en && t < 20) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (halted && !rom_en && !illegal) cnt++;
        end
        check("halt_held", 64'(cnt), 64'd20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
